// File: rtl/ysyx_25040118_pkg.sv
// Shared constants for the NPC instruction sequencer: state encoding, fixed instruction words,
// and the default reset PC.
package ysyx_25040118_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [31:0] INS_NOP          = 32'h0000_0013;
  localparam logic [31:0] INS_EBREAK       = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25040118_seq_if.sv
// IMEM fetch handshake and decoder hand-off bundle between the sequencer (master) and
// the IMEM/decoder side (slave).
interface ysyx_25040118_seq_if #(
  parameter int PC_W = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic [31:0]     dec_ins;
  logic            dec_wen;
  logic            dec_ebreak;

  modport master (
    output imem_req_valid, imem_addr, dec_ins,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_wen, dec_ebreak
  );

  modport slave (
    input  imem_req_valid, imem_addr, dec_ins,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_wen, dec_ebreak
  );
endinterface

// File: rtl/ysyx_25040118_perf_cnt.sv
// 64-bit free-running event counter with enable; wraps modulo 2^64.
module ysyx_25040118_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [63:0] cnt_o
);
  logic [63:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/ysyx_25040118_seq.sv
// Multi-cycle NPC sequencer: fetch, latch, decode settle, write-back gating, halt on ebreak.
// Optional performance counters are built when SEQ_PERF_EN is defined.
//
// state | meaning
// IDLE  | one cycle after reset release
// REQ   | fetch request valid at pc, held until accepted
// WAIT  | waiting for the IMEM response, latched into dec_ins
// EXEC  | decoder settles on dec_ins
// WB    | rf_wen follows dec_wen, pc advances
// HALT  | stopped on ebreak until reset
module ysyx_25040118_seq
  import ysyx_25040118_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_25040118_seq_if.master bus,
  output logic                rf_wen,
  output logic [PC_W-1:0]     pc,
  output logic                halt,
  output logic                busy
`ifdef SEQ_PERF_EN
  ,
  output logic [63:0]         perf_cycle,
  output logic [63:0]         perf_instret
`endif
);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ins_q, ins_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (bus.imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          ins_d   = bus.imem_rsp_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = bus.dec_ebreak ? S_HALT : S_WB;
      S_WB: begin
        pc_d    = pc_q + PC_W'(4);
        state_d = S_REQ;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ins_q   <= INS_NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_addr      = pc_q;
  assign bus.dec_ins        = ins_q;
  assign rf_wen             = (state_q == S_WB) && bus.dec_wen;
  assign pc                 = pc_q;
  assign halt               = (state_q == S_HALT);
  assign busy               = (state_q != S_IDLE) && (state_q != S_HALT);

`ifdef SEQ_PERF_EN
  ysyx_25040118_perf_cnt u_perf_cycle (
    .clk   (clk),
    .rst   (rst),
    .en_i  (busy),
    .cnt_o (perf_cycle)
  );

  ysyx_25040118_perf_cnt u_perf_instret (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == S_WB),
    .cnt_o (perf_instret)
  );
`endif

endmodule
